avalon_accum_slave: RTL

- Avalon-MM slave peripheral: the responder side of the Nios II data bus, with an 8-bit switch/key/LED front end.
- Accumulates the switch value in hardware on each debounced accumulate-key press and clears it on the clear key.
- Exposes SW, ACC, CTRL and STATUS registers to software and drives the green LEDs from the low byte of ACC.
- Raises an interrupt on hardware events. Instantiated in the lab top-level beside the SoC, on a bus-exported slave port.

---
 rtl/accum_pkg.sv | 25 ++
 rtl/avalon_accum_slave_if.sv | 22 ++
 rtl/avalon_accum_slave_key_debounce.sv | 53 +++++
 rtl/avalon_accum_slave.sv | 126 ++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared register map, bit positions and flag structs
// for the Avalon accumulator slave.
package accum_pkg;

  localparam logic [1:0] ADDR_SW     = 2'd0;
  localparam logic [1:0] ADDR_ACC    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_HW_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_OVF    = 0;
  localparam int STAT_EVT    = 1;

  typedef struct packed {
    logic irq_en;
    logic hw_en;
  } ctrl_t;

  typedef struct packed {
    logic evt;
    logic ovf;
  } status_t;

endpackage

// File: rtl/avalon_accum_slave_if.sv
// Avalon-MM slave bus bundle with
// master and slave modports.
interface avalon_accum_slave_if;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [1:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE,
    output AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE,
    input  AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA
  );
endinterface

// File: rtl/avalon_accum_slave_key_debounce.sv
// Key synchronizer, stable-level debouncer and
// registered press pulse on the debounced fall.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept the new level on the sample after
  // DEBOUNCE_CYCLES differing samples were counted.
  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        lvl_d   = s2_q;
        press_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= key_ni;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/avalon_accum_slave.sv
// Avalon-MM switch accumulator with key debounce, LEDs, IRQ.
// Macro ACCUM_SATURATE_EN: saturate instead of wrap.
module avalon_accum_slave
  import accum_pkg::*;
#(
  parameter int ACC_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  avalon_accum_slave_if.slave  avl,
  output logic                 IRQ,
  input  logic [7:0]           SW_IN,
  input  logic                 KEY_ACC_N,
  input  logic                 KEY_CLR_N,
  output logic [7:0]           LED_OUT
);

  logic [7:0]       sw1_q, sw_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  ctrl_t            ctrl_q, ctrl_d;
  status_t          stat_q, stat_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;
  logic [7:0]       led_q;
  logic             acc_p, clr_p;
  logic             wr, rd, ovf_set, evt_set;
  logic [ACC_W:0]   sum;
  logic [31:0]      wd;
  logic             unused_wd;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .key_ni  (KEY_ACC_N),
    .press_o (acc_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .key_ni  (KEY_CLR_N),
    .press_o (clr_p)
  );

  assign wd        = avl.AVL_WRITEDATA;
  assign unused_wd = ^wd;
  assign wr        = avl.AVL_CS & avl.AVL_WRITE;
  assign rd        = avl.AVL_CS & avl.AVL_READ;
  assign sum       = {1'b0, acc_q} + (ACC_W+1)'(sw_q);

  always_comb begin
    acc_d   = acc_q;
    ctrl_d  = ctrl_q;
    stat_d  = stat_q;
    rdata_d = rdata_q;
    ovf_set = 1'b0;
    evt_set = 1'b0;
    if (wr && avl.AVL_ADDR == ADDR_ACC) begin
      acc_d = wd[ACC_W-1:0];
    end else if (clr_p) begin
      acc_d   = '0;
      evt_set = 1'b1;
    end else if (acc_p && ctrl_q.hw_en) begin
      evt_set = 1'b1;
      ovf_set = sum[ACC_W];
`ifdef ACCUM_SATURATE_EN
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end
    if (wr && avl.AVL_ADDR == ADDR_CTRL) begin
      ctrl_d.hw_en  = wd[CTRL_HW_EN];
      ctrl_d.irq_en = wd[CTRL_IRQ_EN];
    end
    if (wr && avl.AVL_ADDR == ADDR_STATUS) begin
      if (wd[STAT_OVF]) stat_d.ovf = 1'b0;
      if (wd[STAT_EVT]) stat_d.evt = 1'b0;
    end
    // hardware set wins over a W1C in the same cycle
    stat_d.ovf = stat_d.ovf | ovf_set;
    stat_d.evt = stat_d.evt | evt_set;
    if (rd) begin
      unique case (1'b1)
        (avl.AVL_ADDR == ADDR_SW):
          rdata_d = {24'h0, sw_q};
        (avl.AVL_ADDR == ADDR_ACC):
          rdata_d = 32'(acc_q);
        (avl.AVL_ADDR == ADDR_CTRL):
          rdata_d = {30'h0, ctrl_q};
        (avl.AVL_ADDR == ADDR_STATUS):
          rdata_d = {30'h0, stat_q};
        default:
          rdata_d = rdata_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sw1_q   <= '0;
      sw_q    <= '0;
      acc_q   <= '0;
      ctrl_q  <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      sw1_q   <= SW_IN;
      sw_q    <= sw1_q;
      acc_q   <= acc_d;
      ctrl_q  <= ctrl_d;
      stat_q  <= stat_d;
      rdata_q <= rdata_d;
      irq_q   <= ctrl_q.irq_en & stat_q.evt;
      led_q   <= acc_q[7:0];
    end
  end

  assign avl.AVL_READDATA = rdata_q;
  assign IRQ              = irq_q;
  assign LED_OUT          = led_q;

endmodule
